// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder arbiter slice.
//   FLAG_*       bit positions inside a {invalid, overflow, underflow} flag vector
//   fp_flags_t   packed flag vector type
//   float_width  total encoded width of a float: sign + exponent + mantissa
package fp_pkg;

   localparam int unsigned FLAG_INVALID   = 2;
   localparam int unsigned FLAG_OVERFLOW  = 1;
   localparam int unsigned FLAG_UNDERFLOW = 0;
   localparam int unsigned NUM_FLAGS      = 3;

   typedef logic [NUM_FLAGS-1:0] fp_flags_t;

   function automatic int unsigned float_width(input int unsigned exp_w,
                                               input int unsigned man_w);
      return exp_w + man_w + 1;
   endfunction

endpackage

// File: rtl/floating_point_adder.sv
// Combinational IEEE-754-style adder/subtractor with parameterised format.
// Handles zeros, subnormals, infinities and NaNs; rounds to nearest-even or
// truncates. Any NaN result is the canonical quiet NaN (sign set).
//   a, b       operands
//   subtract   1: a - b, 0: a + b
//   out        result
//   underflow  tiny and inexact result
//   overflow   result exponent exceeded the finite range
//   invalid    inf - inf or a signalling NaN operand
module floating_point_adder
   import fp_pkg::*;
#(
   parameter int unsigned  EXPONENT_WIDTH                = 8,
   parameter int unsigned  MANTISSA_WIDTH                = 23,
   parameter int unsigned  ROUND_TO_NEAREST_TIES_TO_EVEN = 1,
   localparam int unsigned W = float_width(EXPONENT_WIDTH, MANTISSA_WIDTH)
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         subtract,
   output logic [W-1:0] out,
   output logic         underflow,
   output logic         overflow,
   output logic         invalid
);

   localparam int unsigned E  = EXPONENT_WIDTH;
   localparam int unsigned M  = MANTISSA_WIDTH;
   localparam int unsigned SW = M + 1;  // significand with hidden bit
   localparam int unsigned XW = M + 4;  // plus guard, round, sticky
   localparam int unsigned EW = E + 2;  // working exponent
   localparam logic [E-1:0] EXP_MAX    = '1;
   localparam logic [E-1:0] EXP_MAX_M1 = EXP_MAX - 1'b1;
   localparam logic [W-1:0] QNAN       = {1'b1, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

   logic         sa, sb;
   logic [E-1:0] ea, eb;
   logic [M-1:0] ma, mb;
   logic         a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;

   assign sa = a[W-1];
   assign sb = b[W-1] ^ subtract;  // fold the operation into b's sign
   assign ea = a[W-2:M];
   assign eb = b[W-2:M];
   assign ma = a[M-1:0];
   assign mb = b[M-1:0];

   assign a_nan  = (ea == EXP_MAX) && (ma != '0);
   assign b_nan  = (eb == EXP_MAX) && (mb != '0);
   assign a_inf  = (ea == EXP_MAX) && (ma == '0);
   assign b_inf  = (eb == EXP_MAX) && (mb == '0);
   assign a_snan = a_nan && !ma[M-1];
   assign b_snan = b_nan && !mb[M-1];

   logic          s_big, s_small;
   logic [E-1:0]  er_big, er_small;
   logic [M-1:0]  m_big, m_small;
   logic [EW-1:0] e_big, e_small, align, lz, shamt, e_norm, e_fin;
   logic [SW-1:0] sig_big, sig_small;
   logic [XW-1:0] x_big, x_small, x_shift, lost_mask, norm;
   logic [XW:0]   sum;
   logic [SW:0]   rounded;
   logic [M-1:0]  frac;
   logic          sticky_al, inexact, round_up;
   logic [W-1:0]  finite_res;
   logic          finite_ovf, finite_unf;

   always_comb begin
      // Larger magnitude first so the subtraction never goes negative.
      if ({ea, ma} >= {eb, mb}) begin
         s_big = sa;  er_big = ea;  m_big = ma;
         s_small = sb; er_small = eb; m_small = mb;
      end else begin
         s_big = sb;  er_big = eb;  m_big = mb;
         s_small = sa; er_small = ea; m_small = ma;
      end

      // Subnormals use exponent 1 with no hidden bit.
      e_big     = (er_big == '0) ? EW'(1) : EW'(er_big);
      e_small   = (er_small == '0) ? EW'(1) : EW'(er_small);
      sig_big   = {(er_big != '0), m_big};
      sig_small = {(er_small != '0), m_small};
      x_big     = {sig_big, 3'b000};
      x_small   = {sig_small, 3'b000};
      align     = e_big - e_small;

      lost_mask = '0;
      if (align >= EW'(XW)) begin
         x_shift   = '0;
         sticky_al = |x_small;
      end else begin
         lost_mask = ~({XW{1'b1}} << align);
         x_shift   = x_small >> align;
         sticky_al = |(x_small & lost_mask);
      end
      x_shift[0] = x_shift[0] | sticky_al;

      if (s_big ^ s_small) begin
         sum = {1'b0, x_big} - {1'b0, x_shift};
      end else begin
         sum = {1'b0, x_big} + {1'b0, x_shift};
      end

      lz = EW'(XW);
      for (int i = 0; i < int'(XW); i++) begin
         if (sum[i]) begin
            lz = EW'(int'(XW) - 1 - i);
         end
      end
      // Never normalise below exponent 1; what remains is subnormal.
      shamt = (lz < e_big - EW'(1)) ? lz : e_big - EW'(1);

      if (sum[XW]) begin
         norm   = {sum[XW:2], sum[1] | sum[0]};
         e_norm = e_big + EW'(1);
      end else begin
         norm   = sum[XW-1:0] << shamt;
         e_norm = e_big - shamt;
      end

      inexact  = |norm[2:0];
      round_up = (ROUND_TO_NEAREST_TIES_TO_EVEN != 0) && norm[2] && (norm[1] || norm[0] || norm[3]);
      rounded  = {1'b0, norm[XW-1:3]} + {{SW{1'b0}}, round_up};

      if (rounded[SW]) begin
         e_fin = e_norm + EW'(1);
         frac  = rounded[M:1];
      end else if (!rounded[M]) begin
         e_fin = '0;
         frac  = rounded[M-1:0];
      end else begin
         e_fin = e_norm;
         frac  = rounded[M-1:0];
      end

      finite_ovf = e_fin >= EW'(EXP_MAX);
      finite_unf = (e_fin == '0) && inexact;
      if (finite_ovf) begin
         // Truncation saturates at the largest finite value.
         finite_res = (ROUND_TO_NEAREST_TIES_TO_EVEN != 0) ? {s_big, EXP_MAX, {M{1'b0}}}
                                                           : {s_big, EXP_MAX_M1, {M{1'b1}}};
      end else begin
         finite_res = {s_big, e_fin[E-1:0], frac};
      end

      if (sum == '0) begin
         // Exact cancellation gives +0 unless both inputs were negative.
         finite_res = {s_big & s_small, {(W-1){1'b0}}};
         finite_ovf = 1'b0;
         finite_unf = 1'b0;
      end
   end

   always_comb begin
      out       = finite_res;
      overflow  = finite_ovf;
      underflow = finite_unf;
      invalid   = 1'b0;
      if (a_nan || b_nan) begin
         out       = QNAN;
         overflow  = 1'b0;
         underflow = 1'b0;
         invalid   = a_snan || b_snan;
      end else if (a_inf && b_inf) begin
         overflow  = 1'b0;
         underflow = 1'b0;
         if (sa != sb) begin
            out     = QNAN;
            invalid = 1'b1;
         end else begin
            out = {sa, EXP_MAX, {M{1'b0}}};
         end
      end else if (a_inf || b_inf) begin
         overflow  = 1'b0;
         underflow = 1'b0;
         out       = a_inf ? {sa, EXP_MAX, {M{1'b0}}} : {sb, EXP_MAX, {M{1'b0}}};
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Grants the first asserted request at or above the
// priority pointer, wrapping modulo N. The pointer moves past the granted
// index only when the caller reports the grant was consumed.
//   clk, rst   clock, synchronous active-high reset (pointer -> 0)
//   req        request vector
//   advance    current grant was accepted; move pointer to grant_idx + 1
//   grant      one-hot grant (all zero when nothing is requested)
//   grant_idx  binary index of the grant
module rr_arbiter #(
   parameter int unsigned  N  = 2,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic          found;

   always_comb begin
      int idx;
      found     = 1'b0;
      grant_idx = '0;
      grant     = '0;
      for (int k = 0; k < int'(N); k++) begin
         idx = (int'(ptr_q) + k) % int'(N);
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_idx = IW'(idx);
         end
      end
      if (found) begin
         grant[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && found) begin
         ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one combinational floating-point adder among NUM_REQUESTERS
// requesters through a round-robin arbiter, with a one-deep registered
// result slot that supports back-to-back results under resp_ready.
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        per-requester handshake (ready only to the grantee)
//   req_a, req_b, req_subtract per-requester operands, W bits per requester
//   resp_valid/resp_ready      result handshake
//   resp_out, resp_id          registered result and granted requester index
//   resp_underflow/overflow/invalid  registered per-result flags
//   sticky_flags, sticky_clear {invalid, overflow, underflow} accumulator and clear
module fp_adder_arbiter
   import fp_pkg::*;
#(
   parameter int unsigned  EXPONENT_WIDTH                = 8,
   parameter int unsigned  MANTISSA_WIDTH                = 23,
   parameter int unsigned  ROUND_TO_NEAREST_TIES_TO_EVEN = 1,
   parameter int unsigned  NUM_REQUESTERS                = 2,
   localparam int unsigned W  = float_width(EXPONENT_WIDTH, MANTISSA_WIDTH),
   localparam int unsigned IW = $clog2(NUM_REQUESTERS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQUESTERS-1:0]     req_valid,
   output logic [NUM_REQUESTERS-1:0]     req_ready,
   input  logic [NUM_REQUESTERS*W-1:0]   req_a,
   input  logic [NUM_REQUESTERS*W-1:0]   req_b,
   input  logic [NUM_REQUESTERS-1:0]     req_subtract,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic [W-1:0]                  resp_out,
   output logic [IW-1:0]                 resp_id,
   output logic                          resp_underflow,
   output logic                          resp_overflow,
   output logic                          resp_invalid,
   output fp_flags_t                     sticky_flags,
   input  logic                          sticky_clear
);

   logic [NUM_REQUESTERS-1:0] grant;
   logic [IW-1:0]             grant_idx;
   logic                      slot_free, accept;
   logic [W-1:0]              op_a, op_b, add_out;
   logic                      op_sub, add_unf, add_ovf, add_inv;
   fp_flags_t                 add_flags;

   logic                      resp_valid_q, resp_valid_d;
   logic [W-1:0]              resp_out_q, resp_out_d;
   logic [IW-1:0]             resp_id_q, resp_id_d;
   fp_flags_t                 resp_flags_q, resp_flags_d;
   fp_flags_t                 sticky_q, sticky_d;

   assign slot_free = !resp_valid_q || resp_ready;
   assign req_ready = grant & {NUM_REQUESTERS{slot_free & ~rst}};
   assign accept    = |(req_valid & req_ready);

   rr_arbiter #(
      .N (NUM_REQUESTERS)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign op_a   = req_a[grant_idx*W +: W];
   assign op_b   = req_b[grant_idx*W +: W];
   assign op_sub = req_subtract[grant_idx];

   floating_point_adder #(
      .EXPONENT_WIDTH                (EXPONENT_WIDTH),
      .MANTISSA_WIDTH                (MANTISSA_WIDTH),
      .ROUND_TO_NEAREST_TIES_TO_EVEN (ROUND_TO_NEAREST_TIES_TO_EVEN)
   ) u_add (
      .a         (op_a),
      .b         (op_b),
      .subtract  (op_sub),
      .out       (add_out),
      .underflow (add_unf),
      .overflow  (add_ovf),
      .invalid   (add_inv)
   );

   always_comb begin
      add_flags                 = '0;
      add_flags[FLAG_INVALID]   = add_inv;
      add_flags[FLAG_OVERFLOW]  = add_ovf;
      add_flags[FLAG_UNDERFLOW] = add_unf;
   end

   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_out_d   = resp_out_q;
      resp_id_d    = resp_id_q;
      resp_flags_d = resp_flags_q;
      if (accept) begin
         resp_valid_d = 1'b1;
         resp_out_d   = add_out;
         resp_id_d    = grant_idx;
         resp_flags_d = add_flags;
      end else if (resp_ready) begin
         resp_valid_d = 1'b0;
      end
      // Clear drops the old accumulation; flags accepted this cycle still land.
      sticky_d = (sticky_clear ? '0 : sticky_q) | (accept ? add_flags : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_out_q   <= '0;
         resp_id_q    <= '0;
         resp_flags_q <= '0;
         sticky_q     <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_out_q   <= resp_out_d;
         resp_id_q    <= resp_id_d;
         resp_flags_q <= resp_flags_d;
         sticky_q     <= sticky_d;
      end
   end

   assign resp_valid     = resp_valid_q;
   assign resp_out       = resp_out_q;
   assign resp_id        = resp_id_q;
   assign resp_invalid   = resp_flags_q[FLAG_INVALID];
   assign resp_overflow  = resp_flags_q[FLAG_OVERFLOW];
   assign resp_underflow = resp_flags_q[FLAG_UNDERFLOW];
   assign sticky_flags   = sticky_q;

endmodule

// File: doc/fp_adder_arbiter.md
FP_ADDER_ARBITER -- requirements
Module: fp_adder_arbiter

Interface
REQ-001 SHALL have parameter EXPONENT_WIDTH, default 8, exponent field width passed to the shared adder.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23, mantissa field width passed to the shared adder.
REQ-003 SHALL have parameter ROUND_TO_NEAREST_TIES_TO_EVEN, default 1, rounding mode passed to the shared adder.
REQ-004 SHALL have parameter NUM_REQUESTERS, default 2, legal range 2..8; W = EXPONENT_WIDTH+MANTISSA_WIDTH+1; IW = $clog2(NUM_REQUESTERS).
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, input, NUM_REQUESTERS, per-requester operation request.
REQ-008 SHALL have port req_ready, output, NUM_REQUESTERS, per-requester accept.
REQ-009 SHALL have port req_a, input, NUM_REQUESTERS*W, operand a; requester i occupies bits [i*W +: W].
REQ-010 SHALL have port req_b, input, NUM_REQUESTERS*W, operand b, packed the same way as req_a.
REQ-011 SHALL have port req_subtract, input, NUM_REQUESTERS, 1 = a-b, 0 = a+b.
REQ-012 SHALL have port resp_valid, output, 1, result register holds a valid result.
REQ-013 SHALL have port resp_ready, input, 1, consumer accepts the result.
REQ-014 SHALL have ports resp_out, output, W, registered sum; resp_id, output, IW, index of the granted requester.
REQ-015 SHALL have ports resp_underflow, resp_overflow, resp_invalid, output, 1 each, registered per-result flags.
REQ-016 SHALL have ports sticky_flags, output, 3, {invalid, overflow, underflow} OR-accumulated; sticky_clear, input, 1, clears them.

Function
REQ-017 SHALL define slot_free = !resp_valid || resp_ready.
REQ-018 SHALL drive req_ready[i] high only for the granted requester, and only when slot_free; req_ready SHALL be combinational from req_valid, the priority pointer and slot_free.
REQ-019 SHALL grant round-robin: the first asserted req_valid at or after ptr, searching upward modulo NUM_REQUESTERS.
REQ-020 SHALL load ptr with (granted index + 1) mod NUM_REQUESTERS on each accepted request (req_valid[i] && req_ready[i]), and hold ptr otherwise.
REQ-021 SHALL feed the granted requester's a, b and subtract to one combinationally shared floating_point_adder.
REQ-022 SHALL register the adder's out, its three flags and the grant index into resp_* on acceptance; resp_valid SHALL rise the next cycle (latency 1).
REQ-023 SHALL hold resp_* stable while resp_valid && !resp_ready.
REQ-024 SHALL clear resp_valid on a cycle where resp_ready is high and no request is accepted.
REQ-025 SHALL, when resp_ready and a new acceptance occur in the same cycle, load the new result with no bubble, sustaining one result per cycle.
REQ-026 SHALL OR the flags of each accepted result into sticky_flags; if sticky_clear is asserted in the same cycle, the clear SHALL win for that cycle and the new flags SHALL not be lost; they SHALL be loaded after the clear.
REQ-027 SHALL assert no req_ready when no req_valid is asserted; ptr SHALL be unchanged in that case.

Reset
REQ-028 SHALL, while rst is high, set resp_valid=0, resp_out=0, resp_id=0, resp flags=0, sticky_flags=0, ptr=0, and drive all req_ready low.
REQ-029 SHALL, on reset mid-stream, discard any pending result with no output handshake; the first grant after reset SHALL favour requester 0.

Structure
REQ-030 SHALL place the float-width helper constant and the flag-vector bit positions (INVALID=2, OVERFLOW=1, UNDERFLOW=0) in shared package fp_pkg.
REQ-031 SHALL implement the grant logic as sub-module rr_arbiter (parameter N; inputs clk, rst, req, advance; outputs grant one-hot, grant_idx); the adder SHALL be the existing floating_point_adder instance.

Verification
REQ-032 SHALL cover: req0 a=0x3F800000, b=0x40000000, add -> one cycle later resp_out=0x40400000, resp_id=0, no flags.
REQ-033 SHALL cover: req0 and req1 held valid with resp_ready=1 for 4 cycles -> grants 0,1,0,1, back-to-back resp_valid.
REQ-034 SHALL cover: req1 a=0x7F800000, b=0x7F800000, subtract=1 -> resp_out=0xFFC00000, resp_invalid=1, sticky_flags=3'b100 until sticky_clear.
REQ-035 SHALL cover: resp_ready=0 for 3 cycles with both requesters valid -> req_ready all low and resp_out stable; on release, the next grant follows ptr.
REQ-036 SHALL cover: rst asserted for one cycle while resp_valid=1 -> resp_valid=0 next cycle and the first subsequent grant goes to requester 0.
REQ-037 SHALL cover: a=0x40400000, b=0x3F800000, subtract=1 accepted in the same cycle as sticky_clear -> resp_out=0x40000000 and the clear takes effect.
